// File: rtl/panda_risc_v_icb_arb_2to1_pkg.sv
// Shared definitions for the 2:1 ICB arbiter.
// This file holds the ICB field widths, the master-ID encoding, and small helper functions.
package panda_risc_v_icb_arb_2to1_pkg;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 32;
    localparam int ICB_MASK_W = ICB_DATA_W / 8;

    // Identifies which upstream master owns a command or response.
    typedef enum logic {
        ICB_ARB_ID_S0 = 1'b0,   // instruction fetch unit
        ICB_ARB_ID_S1 = 1'b1    // load/store unit
    } icb_arb_id_e;

    // Returns the master that is not 'id'. The priority pointer uses this to rotate.
    function automatic icb_arb_id_e icb_arb_other(input icb_arb_id_e id);
        return (id == ICB_ARB_ID_S0) ? ICB_ARB_ID_S1 : ICB_ARB_ID_S0;
    endfunction

    // Legal outstanding depths are powers of two from 2 to 16.
    function automatic bit icb_arb_depth_ok(input int depth);
        return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/panda_risc_v_icb_arb_2to1_if.sv
// ICB command/response bundle.
// The master modport is the side that issues commands.
// The slave modport is the side that accepts them.
interface panda_risc_v_icb_arb_2to1_if;
    import panda_risc_v_icb_arb_2to1_pkg::*;

    logic [ICB_ADDR_W-1:0] cmd_addr;
    logic                  cmd_read;
    logic [ICB_DATA_W-1:0] cmd_wdata;
    logic [ICB_MASK_W-1:0] cmd_wmask;
    logic                  cmd_valid;
    logic                  cmd_ready;

    logic [ICB_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_valid;
    logic                  rsp_ready;

    modport master (
        output cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid,
        input  cmd_ready,
        input  rsp_rdata, rsp_err, rsp_valid,
        output rsp_ready
    );

    modport slave (
        input  cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_valid,
        output cmd_ready,
        output rsp_rdata, rsp_err, rsp_valid,
        input  rsp_ready
    );

endinterface

// File: rtl/panda_risc_v_icb_arb_ord_fifo.sv
// Order FIFO for the arbiter.
// It remembers which master issued each accepted command, so each response returns
// to the master that issued the command. The FIFO is 1 bit wide and DEPTH entries deep.
module panda_risc_v_icb_arb_ord_fifo
    import panda_risc_v_icb_arb_2to1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  icb_arb_id_e            push_id,
    input  logic                   pop,
    output icb_arb_id_e            head_id,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    icb_arb_id_e      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    // Ignore a push when the FIFO is full and a pop when it is empty, so that misuse cannot corrupt the count.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Storage for the entries. Reset is not needed because only the occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id;
        end
    end

    assign head_id = mem[rd_ptr];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);
    assign count   = cnt;

endmodule

// File: rtl/panda_risc_v_icb_arb_2to1.sv
// 2:1 ICB arbiter that shares one memory slave between the IFU (s0) and the LSU (s1).
// Commands pass through combinationally. Arbitration is round-robin, and a stalled command keeps its grant.
// Responses are steered back to the issuing master in command order.
module panda_risc_v_icb_arb_2to1
    import panda_risc_v_icb_arb_2to1_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int simulation_delay  = 1
) (
    input  logic                               clk,
    input  logic                               sys_reset,
    panda_risc_v_icb_arb_2to1_if.slave         s0_icb,
    panda_risc_v_icb_arb_2to1_if.slave         s1_icb,
    panda_risc_v_icb_arb_2to1_if.master        m_icb,
    output logic [$clog2(OUTSTANDING_DEPTH):0] outstanding_cnt,
    output logic                               rsp_orphan
);

    // The register-update delay only affects simulation, and this RTL adds no delay of its own.
    // An illegal configuration appears as g_params_invalid in the elaborated hierarchy.
    localparam bit PARAMS_OK = icb_arb_depth_ok(OUTSTANDING_DEPTH) && (simulation_delay >= 0);

    if (!PARAMS_OK) begin : g_params_invalid
    end

    icb_arb_id_e prio_ptr;
    icb_arb_id_e lock_id;
    icb_arb_id_e grant_id;
    icb_arb_id_e head_id;
    logic        locked;
    logic        grant_valid;
    logic        ord_empty;
    logic        ord_full;
    logic        cmd_hs;
    logic        rsp_pop;
    logic        rsp_drop;

    // Grant selection. A command that is stalled keeps the bus. Otherwise a lone requester wins,
    // and when both masters request, the priority pointer decides.
    always_comb begin
        grant_id = ICB_ARB_ID_S0;
        if (locked) begin
            grant_id = lock_id;
        end else if (s0_icb.cmd_valid && s1_icb.cmd_valid) begin
            grant_id = prio_ptr;
        end else if (s1_icb.cmd_valid) begin
            grant_id = ICB_ARB_ID_S1;
        end
    end

    // Command path. This mux places the granted master on the slave bus.
    // The bus is gated off while the FIFO is full or reset is asserted.
    always_comb begin
        m_icb.cmd_addr  = s0_icb.cmd_addr;
        m_icb.cmd_read  = s0_icb.cmd_read;
        m_icb.cmd_wdata = s0_icb.cmd_wdata;
        m_icb.cmd_wmask = s0_icb.cmd_wmask;
        grant_valid     = s0_icb.cmd_valid;
        if (grant_id == ICB_ARB_ID_S1) begin
            m_icb.cmd_addr  = s1_icb.cmd_addr;
            m_icb.cmd_read  = s1_icb.cmd_read;
            m_icb.cmd_wdata = s1_icb.cmd_wdata;
            m_icb.cmd_wmask = s1_icb.cmd_wmask;
            grant_valid     = s1_icb.cmd_valid;
        end
        m_icb.cmd_valid  = grant_valid & ~ord_full & ~sys_reset;
        s0_icb.cmd_ready = m_icb.cmd_ready & ~ord_full & ~sys_reset & (grant_id == ICB_ARB_ID_S0);
        s1_icb.cmd_ready = m_icb.cmd_ready & ~ord_full & ~sys_reset & (grant_id == ICB_ARB_ID_S1);
    end

    assign cmd_hs = m_icb.cmd_valid & m_icb.cmd_ready;

    // Response path. The response goes only to the master at the FIFO head.
    // If nothing is outstanding, the response is accepted and dropped.
    always_comb begin
        s0_icb.rsp_rdata = m_icb.rsp_rdata;
        s1_icb.rsp_rdata = m_icb.rsp_rdata;
        s0_icb.rsp_err   = 1'b0;
        s1_icb.rsp_err   = 1'b0;
        s0_icb.rsp_valid = 1'b0;
        s1_icb.rsp_valid = 1'b0;
        m_icb.rsp_ready  = 1'b1;
        if (!ord_empty) begin
            if (head_id == ICB_ARB_ID_S0) begin
                s0_icb.rsp_valid = m_icb.rsp_valid & ~sys_reset;
                s0_icb.rsp_err   = m_icb.rsp_err;
                m_icb.rsp_ready  = s0_icb.rsp_ready;
            end else begin
                s1_icb.rsp_valid = m_icb.rsp_valid & ~sys_reset;
                s1_icb.rsp_err   = m_icb.rsp_err;
                m_icb.rsp_ready  = s1_icb.rsp_ready;
            end
        end
    end

    assign rsp_pop  = m_icb.rsp_valid & m_icb.rsp_ready & ~ord_empty & ~sys_reset;
    assign rsp_drop = m_icb.rsp_valid & ord_empty & ~sys_reset;

    // Round-robin pointer and grant lock.
    // The pointer moves to the other master on every accepted command.
    // The lock holds while the granted command waits for the slave.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            prio_ptr <= ICB_ARB_ID_S0;
            locked   <= 1'b0;
            lock_id  <= ICB_ARB_ID_S0;
        end else begin
            if (cmd_hs) begin
                prio_ptr <= icb_arb_other(grant_id);
            end
            locked  <= m_icb.cmd_valid & ~m_icb.cmd_ready;
            lock_id <= grant_id;
        end
    end

    // Orphan-response flag. It is a one-cycle pulse after a response arrives with nothing outstanding.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            rsp_orphan <= 1'b0;
        end else begin
            rsp_orphan <= rsp_drop;
        end
    end

    panda_risc_v_icb_arb_ord_fifo #(
        .DEPTH   (OUTSTANDING_DEPTH)
    ) u_ord_fifo (
        .clk     (clk),
        .rst     (sys_reset),
        .push    (cmd_hs),
        .push_id (grant_id),
        .pop     (rsp_pop),
        .head_id (head_id),
        .empty   (ord_empty),
        .full    (ord_full),
        .count   (outstanding_cnt)
    );

endmodule

// File: tb/tb_panda_risc_v_icb_arb_2to1.sv
// Testbench for the 2:1 ICB arbiter.
// It uses directed scenarios followed by randomized traffic.
// A queue-based model of the arbitration and ordering rules predicts every output.
module tb_panda_risc_v_icb_arb_2to1;
    import panda_risc_v_icb_arb_2to1_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             sys_reset;
    logic [CNT_W-1:0] outstanding_cnt;
    logic             rsp_orphan;

    panda_risc_v_icb_arb_2to1_if s0_if();
    panda_risc_v_icb_arb_2to1_if s1_if();
    panda_risc_v_icb_arb_2to1_if m_if();

    panda_risc_v_icb_arb_2to1 #(
        .OUTSTANDING_DEPTH (DEPTH),
        .simulation_delay  (1)
    ) dut (
        .clk             (clk),
        .sys_reset       (sys_reset),
        .s0_icb          (s0_if),
        .s1_icb          (s1_if),
        .m_icb           (m_if),
        .outstanding_cnt (outstanding_cnt),
        .rsp_orphan      (rsp_orphan)
    );

    always #5 clk = ~clk;

    // Model state.
    // The queue holds the owner of each accepted command, oldest first.
    bit mq[$];
    bit prio_m    = 1'b0;
    bit lock_m    = 1'b0;
    bit lock_id_m = 1'b0;
    bit orphan_m  = 1'b0;
    bit hs0, hs1, rsp_hs;
    int dut_grants[$];
    int dut_rsps[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Compare the DUT outputs for the current cycle against the model, then advance the model.
    task automatic eval();
        bit full, v0, v1, g, vg, mr, exp_mv, hs, pop, orph, h, rr;
        #1;
        chk("outstanding_cnt", outstanding_cnt, mq.size());
        chk("rsp_orphan", rsp_orphan, orphan_m);
        hs0 = 0; hs1 = 0; rsp_hs = 0;
        if (sys_reset) begin
            chk("rst_s0_cmd_ready", s0_if.cmd_ready, 0);
            chk("rst_s1_cmd_ready", s1_if.cmd_ready, 0);
            chk("rst_m_cmd_valid",  m_if.cmd_valid, 0);
            chk("rst_s0_rsp_valid", s0_if.rsp_valid, 0);
            chk("rst_s1_rsp_valid", s1_if.rsp_valid, 0);
            mq.delete(); prio_m = 0; lock_m = 0; lock_id_m = 0; orphan_m = 0;
            return;
        end
        v0 = s0_if.cmd_valid; v1 = s1_if.cmd_valid; mr = m_if.cmd_ready;
        full = (mq.size() == DEPTH);
        if (lock_m)        g = lock_id_m;
        else if (v0 && v1) g = prio_m;
        else               g = v1;
        vg = g ? v1 : v0;
        exp_mv = !full && vg;
        chk("m_cmd_valid", m_if.cmd_valid, exp_mv);
        chk("s0_cmd_ready", s0_if.cmd_ready, !full && !g && mr);
        chk("s1_cmd_ready", s1_if.cmd_ready, !full && g && mr);
        if (exp_mv) begin
            chk("m_cmd_addr",  m_if.cmd_addr,  g ? s1_if.cmd_addr  : s0_if.cmd_addr);
            chk("m_cmd_read",  m_if.cmd_read,  g ? s1_if.cmd_read  : s0_if.cmd_read);
            chk("m_cmd_wdata", m_if.cmd_wdata, g ? s1_if.cmd_wdata : s0_if.cmd_wdata);
            chk("m_cmd_wmask", m_if.cmd_wmask, g ? s1_if.cmd_wmask : s0_if.cmd_wmask);
        end
        hs = exp_mv && mr;
        if (hs) begin
            if (g) hs1 = 1; else hs0 = 1;
        end
        if (m_if.cmd_valid === 1'b1 && m_if.cmd_ready === 1'b1)
            dut_grants.push_back(s1_if.cmd_ready === 1'b1 ? 1 : 0);
        pop = 0; orph = 0;
        if (mq.size() != 0) begin
            h  = mq[0];
            rr = h ? s1_if.rsp_ready : s0_if.rsp_ready;
            chk("s0_rsp_valid", s0_if.rsp_valid, m_if.rsp_valid && !h);
            chk("s1_rsp_valid", s1_if.rsp_valid, m_if.rsp_valid && h);
            chk("m_rsp_ready", m_if.rsp_ready, rr);
            if (m_if.rsp_valid) begin
                chk("rsp_rdata", h ? s1_if.rsp_rdata : s0_if.rsp_rdata, m_if.rsp_rdata);
                chk("rsp_err",   h ? s1_if.rsp_err   : s0_if.rsp_err,   m_if.rsp_err);
            end
            pop = m_if.rsp_valid && rr;
        end else begin
            chk("s0_rsp_valid_empty", s0_if.rsp_valid, 0);
            chk("s1_rsp_valid_empty", s1_if.rsp_valid, 0);
            chk("m_rsp_ready_empty", m_if.rsp_ready, 1);
            orph = m_if.rsp_valid;
        end
        if (s0_if.rsp_valid === 1'b1 && s0_if.rsp_ready) dut_rsps.push_back(0);
        if (s1_if.rsp_valid === 1'b1 && s1_if.rsp_ready) dut_rsps.push_back(1);
        rsp_hs = m_if.rsp_valid && (m_if.rsp_ready === 1'b1);
        if (pop) void'(mq.pop_front());
        if (hs) begin
            mq.push_back(g);
            prio_m = !g;
        end
        lock_m    = exp_mv && !mr;
        lock_id_m = g;
        orphan_m  = orph;
    endtask

    task automatic idle();
        sys_reset = 0;
        s0_if.cmd_valid = 0; s0_if.cmd_addr = 0; s0_if.cmd_read = 0; s0_if.cmd_wdata = 0; s0_if.cmd_wmask = 0;
        s1_if.cmd_valid = 0; s1_if.cmd_addr = 0; s1_if.cmd_read = 0; s1_if.cmd_wdata = 0; s1_if.cmd_wmask = 0;
        s0_if.rsp_ready = 1; s1_if.rsp_ready = 1;
        m_if.cmd_ready = 0; m_if.rsp_valid = 0; m_if.rsp_rdata = 0; m_if.rsp_err = 0;
    endtask

    task automatic do_reset();
        idle();
        sys_reset = 1;
        eval();
        tick();
        sys_reset = 0;
    endtask

    task automatic drain();
        s0_if.cmd_valid = 0; s1_if.cmd_valid = 0;
        s0_if.rsp_ready = 1; s1_if.rsp_ready = 1;
        for (int k = 0; k < 2 * DEPTH + 2 && mq.size() != 0; k++) begin
            m_if.rsp_valid = 1; m_if.rsp_rdata = $urandom; m_if.rsp_err = 0;
            eval(); tick();
        end
        m_if.rsp_valid = 0;
    endtask

    initial begin
        idle();
        sys_reset = 1;
        tick();

        // Both masters request every cycle and the slave is always ready: grants and responses alternate.
        do_reset();
        chk("reset_cnt_zero", outstanding_cnt, 0);
        dut_grants.delete(); dut_rsps.delete();
        m_if.cmd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h1000 + i;
            s1_if.cmd_valid = 1; s1_if.cmd_addr = 32'h2000 + i;
            m_if.rsp_valid = (mq.size() != 0); m_if.rsp_rdata = 32'hA000 + i; m_if.rsp_err = 0;
            eval(); tick();
        end
        drain();
        chk("alt_grant_count", dut_grants.size(), 8);
        for (int i = 0; i < 8 && i < dut_grants.size(); i++) chk("alt_grant", dut_grants[i], i % 2);
        chk("alt_rsp_count", dut_rsps.size(), 8);
        for (int i = 0; i < 8 && i < dut_rsps.size(); i++) chk("alt_rsp", dut_rsps[i], i % 2);

        // s1 holds the bus through three stalled cycles while s0 waits.
        do_reset();
        s1_if.cmd_valid = 1; s1_if.cmd_addr = 32'h5111_0000;
        eval(); chk("lock_addr0", m_if.cmd_addr, 32'h5111_0000); tick();
        s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h5000_0000;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("lock_addr_hold", m_if.cmd_addr, 32'h5111_0000);
            chk("lock_s0_ready", s0_if.cmd_ready, 0);
            tick();
        end
        m_if.cmd_ready = 1;
        eval(); chk("lock_s1_hs", s1_if.cmd_ready, 1); tick();
        s1_if.cmd_addr = 32'h5111_0004;
        eval();
        chk("lock_then_s0_addr", m_if.cmd_addr, 32'h5000_0000);
        chk("lock_then_s0_ready", s0_if.cmd_ready, 1);
        tick();
        drain();

        // Fill to the depth limit. A pop in the same cycle does not admit a new command; the command is admitted one cycle later.
        do_reset();
        m_if.cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h7000_0000 + 32'(i * 4);
            eval(); chk("fill_ready", s0_if.cmd_ready, 1); tick();
        end
        s0_if.cmd_addr = 32'h7000_0010;
        eval();
        chk("full_cnt", outstanding_cnt, 4);
        chk("full_m_valid", m_if.cmd_valid, 0);
        chk("full_s0_ready", s0_if.cmd_ready, 0);
        tick();
        m_if.rsp_valid = 1; m_if.rsp_rdata = 32'hBEEF_0001;
        eval();
        chk("full_pop_still_stalled", m_if.cmd_valid, 0);
        chk("full_pop_rsp_s0", s0_if.rsp_valid, 1);
        tick();
        m_if.rsp_valid = 0;
        eval();
        chk("after_pop_cnt", outstanding_cnt, 3);
        chk("after_pop_m_valid", m_if.cmd_valid, 1);
        chk("after_pop_addr", m_if.cmd_addr, 32'h7000_0010);
        tick();
        drain();

        // Issue commands in the order s0, s1, s0. The error on the second response reaches only s1.
        do_reset();
        m_if.cmd_ready = 1;
        s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h100; eval(); tick();
        s0_if.cmd_valid = 0; s1_if.cmd_valid = 1; s1_if.cmd_addr = 32'h200; eval(); tick();
        s1_if.cmd_valid = 0; s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h300; eval(); tick();
        s0_if.cmd_valid = 0;
        m_if.rsp_valid = 1; m_if.rsp_err = 0; m_if.rsp_rdata = 32'hD0;
        eval(); chk("err_r1_s0_valid", s0_if.rsp_valid, 1); chk("err_r1_s0_err", s0_if.rsp_err, 0); tick();
        m_if.rsp_err = 1; m_if.rsp_rdata = 32'hD1;
        eval();
        chk("err_r2_s1_valid", s1_if.rsp_valid, 1); chk("err_r2_s1_err", s1_if.rsp_err, 1);
        chk("err_r2_s0_valid", s0_if.rsp_valid, 0); chk("err_r2_s0_err", s0_if.rsp_err, 0);
        tick();
        m_if.rsp_err = 0; m_if.rsp_rdata = 32'hD2;
        eval(); chk("err_r3_s0_valid", s0_if.rsp_valid, 1); chk("err_r3_s0_err", s0_if.rsp_err, 0); tick();
        m_if.rsp_valid = 0;
        eval(); chk("err_cnt_done", outstanding_cnt, 0); tick();

        // A response arrives while nothing is outstanding.
        do_reset();
        m_if.rsp_valid = 1; m_if.rsp_rdata = 32'hDEAD;
        eval();
        chk("orph_m_ready", m_if.rsp_ready, 1);
        chk("orph_s0_valid", s0_if.rsp_valid, 0);
        chk("orph_s1_valid", s1_if.rsp_valid, 0);
        chk("orph_flag_before", rsp_orphan, 0);
        tick();
        m_if.rsp_valid = 0;
        eval(); chk("orph_flag_pulse", rsp_orphan, 1); tick();
        eval(); chk("orph_flag_clear", rsp_orphan, 0); tick();

        // Reset with two commands outstanding. The count clears, and the pointer returns to s0.
        do_reset();
        m_if.cmd_ready = 1;
        s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h900; eval(); tick();
        s0_if.cmd_addr = 32'h904; eval(); tick();
        s0_if.cmd_valid = 0;
        eval(); chk("rst2_cnt_before", outstanding_cnt, 2); tick();
        s0_if.cmd_valid = 1; s0_if.cmd_addr = 32'h908;
        sys_reset = 1; eval(); tick(); sys_reset = 0;
        s1_if.cmd_valid = 1; s1_if.cmd_addr = 32'hA00;
        eval();
        chk("rst2_cnt_after", outstanding_cnt, 0);
        chk("rst2_s0_first", s0_if.cmd_ready, 1);
        chk("rst2_addr", m_if.cmd_addr, 32'h908);
        tick();
        drain();

        // Randomized traffic. Masters and the responder hold their requests until they are accepted.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!s0_if.cmd_valid || hs0) begin
                s0_if.cmd_valid = ($urandom_range(0, 2) != 0);
                s0_if.cmd_addr = $urandom; s0_if.cmd_read = $urandom_range(0, 1);
                s0_if.cmd_wdata = $urandom; s0_if.cmd_wmask = 4'($urandom);
            end
            if (!s1_if.cmd_valid || hs1) begin
                s1_if.cmd_valid = ($urandom_range(0, 2) != 0);
                s1_if.cmd_addr = $urandom; s1_if.cmd_read = $urandom_range(0, 1);
                s1_if.cmd_wdata = $urandom; s1_if.cmd_wmask = 4'($urandom);
            end
            if (sys_reset || !m_if.rsp_valid || rsp_hs) begin
                if (mq.size() != 0) m_if.rsp_valid = ($urandom_range(0, 1) != 0);
                else                m_if.rsp_valid = ($urandom_range(0, 15) == 0);
                m_if.rsp_rdata = $urandom; m_if.rsp_err = ($urandom_range(0, 7) == 0);
            end
            s0_if.rsp_ready = ($urandom_range(0, 3) != 0);
            s1_if.rsp_ready = ($urandom_range(0, 3) != 0);
            m_if.cmd_ready  = ($urandom_range(0, 9) < 7);
            sys_reset       = ($urandom_range(0, 299) == 0);
            eval(); tick();
        end
        sys_reset = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/panda_risc_v_icb_arb_2to1.md
PANDA_RISC_V_ICB_ARB_2TO1 -- requirements
Module: panda_risc_v_icb_arb_2to1

Interface
REQ-001 SHALL have parameter OUTSTANDING_DEPTH, default 4, meaning max commands accepted but not yet responded (power of 2, 2..16).
REQ-002 SHALL have parameter simulation_delay, default 1, meaning register-update delay in simulation only.
REQ-003 SHALL have port clk  in  1  the single clock.
REQ-004 SHALL have port sys_reset  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports s0_icb_cmd_{addr,read,wdata,wmask,valid}  in  32/1/32/4/1  and s0_icb_cmd_ready  out  1  for the instruction master (IFU) command channel.
REQ-006 SHALL have ports s0_icb_rsp_{rdata,err,valid}  out  32/1/1  and s0_icb_rsp_ready  in  1  for the IFU response channel.
REQ-007 SHALL have s1_icb_cmd_* and s1_icb_rsp_* with identical widths and directions for the data master (LSU).
REQ-008 SHALL have ports m_icb_cmd_{addr,read,wdata,wmask,valid}  out  32/1/32/4/1, m_icb_cmd_ready  in  1, m_icb_rsp_{rdata,err,valid}  in  32/1/1, m_icb_rsp_ready  out  1  to the shared memory slave.
REQ-009 SHALL have port outstanding_cnt  out  $clog2(OUTSTANDING_DEPTH)+1  commands in flight.
REQ-010 SHALL have port rsp_orphan  out  1  one-cycle pulse when a response arrives with nothing outstanding.

Function
REQ-011 SHALL forward the granted master's command combinationally to m_icb_cmd_* (zero added latency); non-granted cmd_ready SHALL be 0.
REQ-012 SHALL arbitrate round-robin: only one valid -> that one wins; both valid -> the master indicated by priority pointer wins.
REQ-013 SHALL toggle the priority pointer to the other master on every m_icb_cmd handshake.
REQ-014 SHALL hold the grant (lock) while m_icb_cmd_valid=1 and m_icb_cmd_ready=0, even if the other master asserts valid; lock released on handshake.
REQ-015 SHALL force m_icb_cmd_valid=0 and both s*_cmd_ready=0 when outstanding_cnt==OUTSTANDING_DEPTH, even if a response pops that cycle.
REQ-016 SHALL push the winner's ID (0=s0, 1=s1) into an order FIFO on each m_icb_cmd handshake.
REQ-017 SHALL route m_icb_rsp_* to the master at FIFO head combinationally; m_icb_rsp_ready SHALL equal that master's rsp_ready; other master's rsp_valid SHALL be 0.
REQ-018 SHALL pop the FIFO on m_icb_rsp handshake; simultaneous push and pop SHALL leave outstanding_cnt unchanged.
REQ-019 SHALL, when FIFO empty and m_icb_rsp_valid=1, drive m_icb_rsp_ready=1, drop the response, and pulse rsp_orphan next cycle.
REQ-020 SHALL treat pointer/count wrap modulo OUTSTANDING_DEPTH with no data loss.

Reset
REQ-021 SHALL on sys_reset: empty FIFO, outstanding_cnt=0, priority pointer=s0, lock cleared, rsp_orphan=0.
REQ-022 SHALL during reset drive all cmd_ready/cmd_valid/rsp_valid outputs to 0; an in-flight command at reset SHALL be abandoned (no response routed).

Structure
REQ-023 SHALL place master-ID encoding (ICB_ARB_ID_S0=0, ICB_ARB_ID_S1=1) and ICB field widths in the shared panda_risc_v package.
REQ-024 SHALL implement the order FIFO as sub-module panda_risc_v_icb_arb_ord_fifo (1-bit wide, OUTSTANDING_DEPTH deep, count output).

Verification
REQ-025 SHALL cover: s0 and s1 valid every cycle, slave always ready -> grants alternate s0,s1,s0,s1; responses return to matching masters.
REQ-026 SHALL cover: s1 granted, m_cmd_ready=0 for 3 cycles while s0 valid -> m_cmd_addr stays s1's for all 3 cycles, s0 granted after handshake.
REQ-027 SHALL cover: 4 commands accepted, no responses -> outstanding_cnt=4, 5th command stalled; one response pops -> 5th accepted next cycle.
REQ-028 SHALL cover: order s0,s1,s0 issued, rsp err=1 on 2nd -> s1_icb_rsp_err=1 only; s0 unaffected.
REQ-029 SHALL cover: m_icb_rsp_valid with FIFO empty -> rsp_orphan=1 one cycle, no s*_rsp_valid.
REQ-030 SHALL cover: sys_reset asserted with 2 outstanding -> next cycle outstanding_cnt=0, pointer=s0.
